// File: rtl/can_tx_dominant_guard.sv
// CAN TX dominant-timeout guard.
// Forwards the MSS CAN TX to the transceiver pin with one registered cycle of
// latency. A TX stuck dominant for TIMEOUT_CYCLES forces the pin recessive.
// The pin is released only after the bus has been idle (TX and RX both
// recessive) for RECOVER_IDLE_CYCLES. Either the release is automatic, or
// it is held until clear_fault. A saturating trip counter feeds housekeeping.
module can_tx_dominant_guard #(
  parameter int TIMEOUT_CYCLES      = 50000,
  parameter int RECOVER_IDLE_CYCLES = 4400,
  parameter bit AUTO_RECOVER        = 1'b1,
  parameter int CNT_WIDTH           = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CAN_TX_M2F,
  input  logic       CAN_RX_F2M,
  input  logic       enable,
  input  logic       clear_fault,
  output logic       can_tx_out,
  output logic       fault,
  output logic       trip_pulse,
  output logic [7:0] fault_count
);

  typedef enum logic [1:0] {
    ST_PASS    = 2'd0,
    ST_TRIP    = 2'd1,
    ST_LATCHED = 2'd2
  } state_e;

  // Counter value held on the edge that sees the final qualifying cycle.
  localparam logic [CNT_WIDTH-1:0] DOM_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(RECOVER_IDLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] dom_cnt_q, dom_cnt_d;
  logic [CNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 tx_out_q, tx_out_d;
  logic                 fault_q, fault_d;
  logic                 trip_q, trip_d;
  logic [7:0]           fcnt_q, fcnt_d;

  // Saturating increment for the cycle counters (never wraps to zero).
  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Saturating increment for the 8-bit trip counter.
  function automatic logic [7:0] sat_inc_fc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Two-flop synchroniser for the asynchronous transceiver RX; idles recessive.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= CAN_RX_F2M;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Guard state, counters and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_PASS;
      dom_cnt_q  <= '0;
      idle_cnt_q <= '0;
      tx_out_q   <= 1'b1;
      fault_q    <= 1'b0;
      trip_q     <= 1'b0;
      fcnt_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      dom_cnt_q  <= dom_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      tx_out_q   <= tx_out_d;
      fault_q    <= fault_d;
      trip_q     <= trip_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Next-state logic; clear_fault is applied before a coincident trip increment.
  always_comb begin
    state_d    = state_q;
    dom_cnt_d  = dom_cnt_q;
    idle_cnt_d = idle_cnt_q;
    tx_out_d   = CAN_TX_M2F;
    trip_d     = 1'b0;
    fcnt_d     = clear_fault ? 8'd0 : fcnt_q;

    if (!enable) begin
      state_d    = ST_PASS;
      dom_cnt_d  = '0;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_PASS: begin
          if (!CAN_TX_M2F) begin
            if (dom_cnt_q == DOM_LAST) begin
              state_d    = ST_TRIP;
              tx_out_d   = 1'b1;
              trip_d     = 1'b1;
              fcnt_d     = sat_inc_fc(fcnt_d);
              dom_cnt_d  = '0;
              idle_cnt_d = '0;
            end else begin
              dom_cnt_d = sat_inc_cnt(dom_cnt_q);
            end
          end else begin
            dom_cnt_d = '0;
          end
        end
        ST_TRIP: begin
          tx_out_d = 1'b1;
          if (CAN_TX_M2F && rx_s_q) begin
            if (idle_cnt_q == IDLE_LAST) begin
              state_d    = AUTO_RECOVER ? ST_PASS : ST_LATCHED;
              idle_cnt_d = '0;
              dom_cnt_d  = '0;
            end else begin
              idle_cnt_d = sat_inc_cnt(idle_cnt_q);
            end
          end else begin
            idle_cnt_d = '0;
          end
        end
        ST_LATCHED: begin
          tx_out_d   = 1'b1;
          dom_cnt_d  = '0;
          idle_cnt_d = '0;
          if (clear_fault) begin
            state_d = ST_PASS;
          end
        end
        default: begin
          state_d    = ST_PASS;
          tx_out_d   = 1'b1;
          dom_cnt_d  = '0;
          idle_cnt_d = '0;
        end
      endcase
    end

    fault_d = (state_d != ST_PASS);
  end

  assign can_tx_out  = tx_out_q;
  assign fault       = fault_q;
  assign trip_pulse  = trip_q;
  assign fault_count = fcnt_q;

endmodule

// File: tb/tb_can_tx_dominant_guard.sv
// Testbench for can_tx_dominant_guard: one auto-recovering and one latching
// instance share stimulus and are compared every cycle against a behavioural
// model built from run lengths of dominant and idle cycles.
module tb_can_tx_dominant_guard;

  localparam int T = 8;
  localparam int R = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       tx, rx, en, clr;
  logic       out_a, fault_a, pulse_a;
  logic [7:0] cnt_a;
  logic       out_l, fault_l, pulse_l;
  logic [7:0] cnt_l;

  int total = 0;
  int bad   = 0;
  string phase = "init";

  // Model state. mode: 0 = passing, 1 = tripped, 2 = latched.
  int m_mode [2];
  int m_dom  [2];
  int m_idle [2];
  int m_cnt  [2];
  bit m_out  [2];
  bit m_pulse[2];
  bit rx_hist[2];   // [0] newest sample, [1] value seen by the guard

  can_tx_dominant_guard #(
    .TIMEOUT_CYCLES(T), .RECOVER_IDLE_CYCLES(R), .AUTO_RECOVER(1'b1), .CNT_WIDTH(16)
  ) dut_a (
    .CLK(CLK), .RESET(RESET), .CAN_TX_M2F(tx), .CAN_RX_F2M(rx), .enable(en),
    .clear_fault(clr), .can_tx_out(out_a), .fault(fault_a), .trip_pulse(pulse_a),
    .fault_count(cnt_a)
  );

  can_tx_dominant_guard #(
    .TIMEOUT_CYCLES(T), .RECOVER_IDLE_CYCLES(R), .AUTO_RECOVER(1'b0), .CNT_WIDTH(16)
  ) dut_l (
    .CLK(CLK), .RESET(RESET), .CAN_TX_M2F(tx), .CAN_RX_F2M(rx), .enable(en),
    .clear_fault(clr), .can_tx_out(out_l), .fault(fault_l), .trip_pulse(pulse_l),
    .fault_count(cnt_l)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: %s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_dom[k] = 0; m_idle[k] = 0; m_cnt[k] = 0;
      m_out[k] = 1'b1; m_pulse[k] = 1'b0;
    end
    rx_hist[0] = 1'b1;
    rx_hist[1] = 1'b1;
  endtask

  // One clock edge of the behavioural model, using the inputs present at the edge.
  task automatic model_edge();
    bit rs;
    rs = rx_hist[1];
    rx_hist[1] = rx_hist[0];
    rx_hist[0] = rx;
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 1'b0;
      if (clr) m_cnt[k] = 0;
      if (!en) begin
        m_mode[k] = 0; m_dom[k] = 0; m_idle[k] = 0; m_out[k] = tx;
      end else if (m_mode[k] == 0) begin
        m_dom[k] = tx ? 0 : m_dom[k] + 1;
        m_out[k] = tx;
        if (m_dom[k] >= T) begin
          m_mode[k] = 1; m_out[k] = 1'b1; m_pulse[k] = 1'b1;
          m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
          m_dom[k] = 0; m_idle[k] = 0;
        end
      end else if (m_mode[k] == 1) begin
        m_out[k] = 1'b1;
        m_idle[k] = (tx && rs) ? m_idle[k] + 1 : 0;
        if (m_idle[k] >= R) begin
          m_mode[k] = (k == 0) ? 0 : 2;
          m_idle[k] = 0; m_dom[k] = 0;
        end
      end else begin
        m_out[k] = 1'b1;
        if (clr) m_mode[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("out_a",   out_a,   m_out[0]);
    chk("fault_a", fault_a, (m_mode[0] != 0));
    chk("pulse_a", pulse_a, m_pulse[0]);
    chk("cnt_a",   cnt_a,   8'(m_cnt[0]));
    chk("out_l",   out_l,   m_out[1]);
    chk("fault_l", fault_l, (m_mode[1] != 0));
    chk("pulse_l", pulse_l, m_pulse[1]);
    chk("cnt_l",   cnt_l,   8'(m_cnt[1]));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int len;

    // Reset with TX dominant: pin must stay recessive.
    phase = "reset";
    RESET = 1'b1; tx = 1'b0; rx = 1'b1; en = 1'b1; clr = 1'b0;
    model_reset();
    #22;
    check_all();
    chk("reset_out_a", out_a, 8'd1);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Toggling TX after release: one-cycle delayed copy.
    phase = "toggle";
    for (int i = 0; i < 10; i++) begin
      tx = 1'($urandom_range(0, 1));
      step();
    end

    // Longest legal dominant run.
    phase = "legal_dom";
    tx = 1'b1; step();
    tx = 1'b0; steps(T - 1);
    chk("legal_out_a", out_a, 8'd0);
    tx = 1'b1; steps(3);
    chk("legal_fault_a", fault_a, 8'd0);

    // Stuck dominant trips on the T-th dominant sample.
    phase = "stuck";
    tx = 1'b0; steps(T - 1);
    step();
    chk("stuck_pulse_a", pulse_a, 8'd1);
    chk("stuck_out_a", out_a, 8'd1);
    steps(12);
    chk("stuck_cnt_a", cnt_a, 8'd1);

    // Recovery with an RX glitch during the idle count.
    phase = "recover";
    tx = 1'b1; rx = 1'b1; steps(3);
    rx = 1'b0; step();
    rx = 1'b1; steps(8);
    chk("recover_fault_a", fault_a, 8'd0);
    chk("latched_fault_l", fault_l, 8'd1);

    // Longer RX activity: the two-flop delay keeps the guard tripped.
    phase = "rx_busy";
    tx = 1'b0; steps(T + 2);
    tx = 1'b1; rx = 1'b0; steps(5);
    rx = 1'b1; steps(R + 3);

    // Latched instance released only by clear_fault.
    phase = "clear";
    clr = 1'b1; step();
    clr = 1'b0;
    chk("clear_fault_l", fault_l, 8'd0);
    chk("clear_cnt_l", cnt_l, 8'd0);
    tx = 1'b0; steps(3);

    // Randomized traffic with occasional enable drops and clears.
    phase = "random";
    for (int r = 0; r < 150; r++) begin
      tx  = 1'($urandom_range(0, 1));
      len = tx ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 12));
      for (int c = 0; c < len; c++) begin
        rx  = ($urandom_range(0, 7) != 0);
        en  = ($urandom_range(0, 31) != 0);
        clr = ($urandom_range(0, 39) == 0);
        step();
      end
    end
    en = 1'b1; clr = 1'b0; rx = 1'b1; tx = 1'b1;
    steps(R + 4);
    clr = 1'b1; step();
    clr = 1'b0; step();

    // Saturation of the trip counter; enable drop releases both instances.
    phase = "saturate";
    for (int i = 0; i < 300; i++) begin
      tx = 1'b0; steps(T);
      tx = 1'b1; en = 1'b0; step();
      en = 1'b1;
    end
    chk("sat_cnt_a", cnt_a, 8'd255);
    chk("sat_cnt_l", cnt_l, 8'd255);

    // Enable dropped mid-trip releases the pin on the next edge.
    phase = "enable_drop";
    tx = 1'b0; steps(T + 2);
    en = 1'b0; step();
    chk("drop_fault_a", fault_a, 8'd0);
    chk("drop_out_a", out_a, 8'd0);
    chk("drop_cnt_a", cnt_a, 8'd255);
    en = 1'b1; tx = 1'b1; step();

    // clear_fault coinciding with the trip edge.
    phase = "clear_on_trip";
    tx = 1'b0; steps(T - 1);
    clr = 1'b1; step();
    clr = 1'b0;
    chk("cot_pulse_a", pulse_a, 8'd1);
    chk("cot_cnt_a", cnt_a, 8'd1);
    chk("cot_fault_a", fault_a, 8'd1);
    steps(2);

    // Reset asserted mid-operation takes effect without a clock edge.
    phase = "mid_reset";
    tx = 1'b1; en = 1'b0; step();
    en = 1'b1; tx = 1'b0; steps(3);
    #2;
    RESET = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge CLK); #1;
    check_all();
    RESET = 1'b0;
    steps(T + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_tx_dominant_guard.md
Name: can_tx_dominant_guard

Overview:
Fabric stage between the MSS CAN controller output (CAN_TX_M2F) and the CAN transceiver TXD pin. It passes TX through with one registered cycle of latency. If TX stays dominant (0) too long, it forces the pin recessive (1) so a hung controller or firmware fault cannot lock up the satellite CAN bus. Release happens only after the bus is seen idle, and a saturating fault counter is provided for housekeeping telemetry.

Parameters:
TIMEOUT_CYCLES, 50000, consecutive dominant CLK cycles on CAN_TX_M2F that trip the guard (1 ms at 50 MHz)
RECOVER_IDLE_CYCLES, 4400, consecutive cycles with TX and RX both recessive required before leaving TRIP (11 bits at 125 kbit/s)
AUTO_RECOVER, 1, 1 = return to PASS after idle; 0 = go to LATCHED and wait for clear_fault
CNT_WIDTH, 16, width of dominant and idle counters; must hold both cycle-count parameters

Ports:
CLK  in  1  fabric clock (FAB_CCC_GL0 domain)
RESET  in  1  asynchronous, active-high reset
CAN_TX_M2F  in  1  TX from MSS CAN, synchronous to CLK
CAN_RX_F2M  in  1  RX from transceiver, asynchronous
enable  in  1  1 = guard active; 0 = plain registered pass-through
clear_fault  in  1  single-cycle pulse: clears fault_count, releases LATCHED
can_tx_out  out  1  registered TX to pin
fault  out  1  high while in TRIP or LATCHED
trip_pulse  out  1  one-cycle pulse on entry to TRIP
fault_count  out  8  saturating count of trips

Behaviour:
- Reset (async assert, sync release): can_tx_out=1, fault=0, trip_pulse=0, fault_count=0, state=PASS, counters=0, RX synchroniser flops=1.
- CAN_RX_F2M goes through a 2-flop synchroniser (rx_s). CAN_TX_M2F is used directly (tx).
- States are PASS, TRIP, LATCHED. fault = (state != PASS), registered with the state.
- PASS:
  - can_tx_out <= tx on each edge (1-cycle latency).
  - dom_cnt increments when tx=0 and clears to 0 when tx=1.
  - On the edge that samples the TIMEOUT_CYCLES-th consecutive dominant tx: state<=TRIP, can_tx_out<=1, trip_pulse<=1 for one cycle, fault_count<=fault_count+1 (saturates at 255).
  - Result: can_tx_out is dominant for at most TIMEOUT_CYCLES-1 cycles.
- TRIP:
  - can_tx_out held at 1.
  - idle_cnt increments when tx=1 and rx_s=1, and clears to 0 otherwise.
  - On the edge that samples the RECOVER_IDLE_CYCLES-th consecutive idle cycle: go to PASS if AUTO_RECOVER=1, else go to LATCHED. dom_cnt=0 and idle_cnt=0 on exit.
  - The first PASS cycle forwards tx normally.
- LATCHED: can_tx_out held at 1. A clear_fault pulse moves the state to PASS.
- clear_fault:
  - In any state, sets fault_count<=0.
  - If it coincides with a trip edge, the clear is applied first, so fault_count=1 and the state goes to TRIP.
  - In TRIP it has no state effect.
- enable=0:
  - state is forced to PASS and both counters to 0 on the next edge; fault drops to 0 on that edge; fault_count is retained.
  - can_tx_out <= tx; trip never occurs.
  - Deasserting enable mid-TRIP releases the pin on the next edge.
- RESET asserted mid-operation immediately forces can_tx_out=1 and returns everything to reset values.
- Counter arithmetic is unsigned and saturates at terminal values; there is no wrap-around.

Test Plan:
(All scenarios use TIMEOUT_CYCLES=8, RECOVER_IDLE_CYCLES=4.)
1. Reset sequence: assert RESET with CAN_TX_M2F=0 -> can_tx_out=1, fault=0, fault_count=0; release with tx toggling -> can_tx_out equals tx delayed 1 cycle.
2. Legal dominant: tx=0 for 7 cycles, then 1 -> can_tx_out is 0 for 7 cycles, no trip_pulse, fault=0.
3. Stuck dominant: tx=0 for 20 cycles -> can_tx_out 0 for 7 cycles, 1 from the 8th edge on; trip_pulse high exactly 1 cycle; fault=1; fault_count=1.
4. Auto recovery (AUTO_RECOVER=1): after test 3, tx=1 and rx recessive 3 cycles, one rx dominant glitch, then 4 recessive -> state stays TRIP until 4 uninterrupted cycles plus 2-cycle sync delay, then fault=0 and tx forwarded.
5. Latched mode (AUTO_RECOVER=0): trip then idle 4 -> fault stays 1, can_tx_out=1; pulse clear_fault -> PASS, fault=0, fault_count=0.
6. Boundaries: 300 trips -> fault_count=255; enable=0 mid-TRIP -> next edge fault=0, can_tx_out=tx; clear_fault on trip edge -> fault_count=1.
